// File: rtl/img_stream_pkg.sv
// Shared definitions for the image stream generator: FSM encoding and bus widths.
package img_stream_pkg;

    localparam int unsigned ADDR_W = 20;
    localparam int unsigned PIX_W  = 8;

    typedef enum logic [2:0] {
        StIdle,
        StVback,
        StLine,
        StHblank,
        StVfront
    } state_e;

endpackage

// File: rtl/img_sync_delay.sv
// Two-stage delay line for vsync/href; the first href stage is exposed so the
// pixel register can gate its capture one cycle ahead of the output.
module img_sync_delay (
    input  logic clk,
    input  logic rst,
    input  logic vsync_src,
    input  logic href_src,
    output logic href_stage1,
    output logic vsync_dly,
    output logic href_dly
);

    logic vsync_stage1;

    always_ff @(posedge clk) begin
        if (rst) begin
            vsync_stage1 <= 1'b0;
            href_stage1  <= 1'b0;
            vsync_dly    <= 1'b0;
            href_dly     <= 1'b0;
        end else begin
            vsync_stage1 <= vsync_src;
            href_stage1  <= href_src;
            vsync_dly    <= vsync_stage1;
            href_dly     <= href_stage1;
        end
    end

endmodule

// File: rtl/img_stream_gen.sv
// Raster-order image stream generator: reads pixels from memory and emits a
// vsync/href/gray stream. Optional test pattern via IMG_STREAM_TEST_PATTERN_EN.
module img_stream_gen
    import img_stream_pkg::*;
#(
    parameter logic [10:0] IMG_HDISP = 11'd640,
    parameter logic [10:0] IMG_VDISP = 11'd480,
    parameter logic [7:0]  H_BLANK   = 8'd160,
    parameter logic [7:0]  V_BACK    = 8'd20,
    parameter logic [7:0]  V_FRONT   = 8'd20
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              continuous,
`ifdef IMG_STREAM_TEST_PATTERN_EN
    input  logic              pattern_sel,
`endif
    output logic              busy,
    output logic              frame_done,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [PIX_W-1:0]  rd_data,
    output logic              per_img_vsync,
    output logic              per_img_href,
    output logic [PIX_W-1:0]  per_img_gray
);

    state_e            state_q, state_d;
    logic [10:0]       col_q, col_d;
    logic [10:0]       line_q, line_d;
    logic [7:0]        phase_q, phase_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              last_line;
    logic              vsync_i, href_i;
    logic              href_stage1;
    logic [PIX_W-1:0]  pix_src;
    logic [PIX_W-1:0]  gray_q;

    assign last_line = (line_q == IMG_VDISP - 11'd1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            col_q   <= '0;
            line_q  <= '0;
            phase_q <= '0;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            line_q  <= line_d;
            phase_q <= phase_d;
            addr_q  <= addr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        line_d  = line_q;
        phase_d = phase_q;
        addr_d  = addr_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StVback;
                    phase_d = '0;
                    addr_d  = '0;
                end
            end
            StVback: begin
                if (phase_q == V_BACK - 8'd1) begin
                    state_d = StLine;
                    phase_d = '0;
                    col_d   = '0;
                    line_d  = '0;
                end else begin
                    phase_d = phase_q + 8'd1;
                end
            end
            StLine: begin
                addr_d = addr_q + 1'b1;
                if (col_q == IMG_HDISP - 11'd1) begin
                    col_d = '0;
                    // With no horizontal blank, lines run back to back.
                    if (H_BLANK == 8'd0) begin
                        if (last_line) begin
                            state_d = StVfront;
                            line_d  = '0;
                        end else begin
                            line_d = line_q + 11'd1;
                        end
                    end else begin
                        state_d = StHblank;
                        phase_d = '0;
                    end
                end else begin
                    col_d = col_q + 11'd1;
                end
            end
            StHblank: begin
                if (phase_q == H_BLANK - 8'd1) begin
                    phase_d = '0;
                    if (last_line) begin
                        state_d = StVfront;
                        line_d  = '0;
                    end else begin
                        state_d = StLine;
                        line_d  = line_q + 11'd1;
                    end
                end else begin
                    phase_d = phase_q + 8'd1;
                end
            end
            StVfront: begin
                if (phase_q == V_FRONT - 8'd1) begin
                    phase_d = '0;
                    if (continuous) begin
                        state_d = StVback;
                        addr_d  = '0;
                    end else begin
                        state_d = StIdle;
                    end
                end else begin
                    phase_d = phase_q + 8'd1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign busy       = (state_q != StIdle);
    assign frame_done = (state_q == StVfront) && (phase_q == V_FRONT - 8'd1);
    assign vsync_i    = (state_q == StVback) || (state_q == StLine) || (state_q == StHblank);
    assign href_i     = (state_q == StLine);
    assign rd_addr    = addr_q;

`ifdef IMG_STREAM_TEST_PATTERN_EN
    logic             pat_sel_q;
    logic [PIX_W-1:0] pat_q;

    // Pattern value is registered so it lines up with memory read latency.
    always_ff @(posedge clk) begin
        if (rst) begin
            pat_sel_q <= 1'b0;
            pat_q     <= '0;
        end else begin
            pat_sel_q <= pattern_sel;
            pat_q     <= col_q[PIX_W-1:0] + line_q[PIX_W-1:0];
        end
    end

    assign rd_en   = href_i & ~pattern_sel;
    assign pix_src = pat_sel_q ? pat_q : rd_data;
`else
    assign rd_en   = href_i;
    assign pix_src = rd_data;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            gray_q <= '0;
        end else begin
            gray_q <= href_stage1 ? pix_src : '0;
        end
    end

    assign per_img_gray = gray_q;

    img_sync_delay u_sync_delay (
        .clk         (clk),
        .rst         (rst),
        .vsync_src   (vsync_i),
        .href_src    (href_i),
        .href_stage1 (href_stage1),
        .vsync_dly   (per_img_vsync),
        .href_dly    (per_img_href)
    );

endmodule

// File: tb/tb_img_stream_gen.sv
// Self-checking bench for img_stream_gen with a small frame geometry; exercises
// the test pattern path only when IMG_STREAM_TEST_PATTERN_EN is defined.
module tb_img_stream_gen;

    localparam int HDN = 4;
    localparam int VDN = 3;
    localparam int HBN = 2;
    localparam int VBN = 3;
    localparam int VFN = 2;
    localparam int LINE_LEN   = HDN + HBN;
    localparam int ACTIVE_END = VBN + VDN * LINE_LEN;
    localparam int FRAME_LEN  = ACTIVE_END + VFN;

    logic        clk = 1'b0;
    logic        rst, start, continuous;
    logic        busy, frame_done, rd_en;
    logic [19:0] rd_addr;
    logic [7:0]  rd_data = 8'hA5;
    logic        per_img_vsync, per_img_href;
    logic [7:0]  per_img_gray;
`ifdef IMG_STREAM_TEST_PATTERN_EN
    logic        pattern_sel;
`endif

    img_stream_gen #(
        .IMG_HDISP (11'd4),
        .IMG_VDISP (11'd3),
        .H_BLANK   (8'd2),
        .V_BACK    (8'd3),
        .V_FRONT   (8'd2)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .continuous    (continuous),
`ifdef IMG_STREAM_TEST_PATTERN_EN
        .pattern_sel   (pattern_sel),
`endif
        .busy          (busy),
        .frame_done    (frame_done),
        .rd_en         (rd_en),
        .rd_addr       (rd_addr),
        .rd_data       (rd_data),
        .per_img_vsync (per_img_vsync),
        .per_img_href  (per_img_href),
        .per_img_gray  (per_img_gray)
    );

    always #5 clk = ~clk;

    // Memory model: data equals the low byte of the address, garbage when idle.
    always @(posedge clk) rd_data <= rd_en ? rd_addr[7:0] : 8'hA5;

    // Frame model: a frame is a timeline of FRAME_LEN cycles indexed by m_off.
    bit       m_act = 1'b0;
    int       m_off = 0;
    bit       m_v1 = 1'b0, m_v2 = 1'b0, m_h1 = 1'b0, m_h2 = 1'b0;
    bit [7:0] m_g1 = 8'h0, m_g2 = 8'h0;
    bit       pat_now;

`ifdef IMG_STREAM_TEST_PATTERN_EN
    assign pat_now = pattern_sel;
`else
    assign pat_now = 1'b0;
`endif

    function automatic bit f_href(int off);
        return off >= VBN && off < ACTIVE_END && ((off - VBN) % LINE_LEN) < HDN;
    endfunction

    function automatic int f_addr(int off);
        return ((off - VBN) / LINE_LEN) * HDN + ((off - VBN) % LINE_LEN);
    endfunction

    function automatic bit [7:0] f_pix(int off, bit pat);
        int ln, cl;
        ln = (off - VBN) / LINE_LEN;
        cl = (off - VBN) % LINE_LEN;
        return pat ? 8'((ln + cl) % 256) : 8'(f_addr(off) % 256);
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_act <= 1'b0; m_off <= 0;
            m_v1 <= 1'b0; m_v2 <= 1'b0; m_h1 <= 1'b0; m_h2 <= 1'b0;
            m_g1 <= 8'h0; m_g2 <= 8'h0;
        end else begin
            m_v2 <= m_v1; m_h2 <= m_h1; m_g2 <= m_g1;
            m_v1 <= m_act && m_off < ACTIVE_END;
            m_h1 <= m_act && f_href(m_off);
            m_g1 <= f_pix(m_off, pat_now);
            if (!m_act) begin
                if (start) begin m_act <= 1'b1; m_off <= 0; end
            end else if (m_off == FRAME_LEN - 1) begin
                if (continuous) m_off <= 0; else m_act <= 1'b0;
            end else begin
                m_off <= m_off + 1;
            end
        end
    end

    int checks = 0;
    int errors = 0;
    int cyc, first_vs, first_h, href_cnt, href_rises, fd_cnt, rden_cnt;
    bit prev_h;
    logic [7:0]  gq[$];
    logic [19:0] aq[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare();
        bit e_rden;
        e_rden = m_act && f_href(m_off) && !pat_now;
        chk("busy", 32'(busy), 32'(m_act));
        chk("frame_done", 32'(frame_done), 32'(m_act && m_off == FRAME_LEN - 1));
        chk("rd_en", 32'(rd_en), 32'(e_rden));
        if (e_rden) chk("rd_addr", 32'(rd_addr), 32'(f_addr(m_off)));
        chk("vsync", 32'(per_img_vsync), 32'(m_v2));
        chk("href", 32'(per_img_href), 32'(m_h2));
        chk("gray", 32'(per_img_gray), 32'(m_h2 ? m_g2 : 8'h0));
    endtask

    task automatic clear_stats();
        cyc = 0; first_vs = -1; first_h = -1; href_cnt = 0; href_rises = 0;
        fd_cnt = 0; rden_cnt = 0; prev_h = 1'b0;
        gq.delete(); aq.delete();
    endtask

    task automatic step();
        @(negedge clk);
        cyc++;
        compare();
        if (per_img_vsync && first_vs < 0) first_vs = cyc;
        if (per_img_href && first_h < 0) first_h = cyc;
        if (per_img_href) begin href_cnt++; gq.push_back(per_img_gray); end
        if (per_img_href && !prev_h) href_rises++;
        prev_h = per_img_href;
        if (frame_done) fd_cnt++;
        if (rd_en) begin rden_cnt++; aq.push_back(rd_addr); end
    endtask

    initial begin
        int n;
        rst = 1'b1; start = 1'b0; continuous = 1'b0;
`ifdef IMG_STREAM_TEST_PATTERN_EN
        pattern_sel = 1'b0;
`endif
        clear_stats();
        repeat (3) step();
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_addr", 32'(rd_addr), 32'd0);
        chk("rst_vsync", 32'(per_img_vsync), 32'd0);
        rst = 1'b0;
        step();

        // Single frame, with a stray start mid-frame that must be ignored.
        clear_stats();
        start = 1'b1;
        step();
        start = 1'b0;
        while (cyc < 8) step();
        start = 1'b1;
        step();
        start = 1'b0;
        while (cyc < 40) step();
        chk("first_vsync_cycle", 32'(first_vs), 32'd3);
        chk("first_href_cycle", 32'(first_h), 32'd6);
        chk("href_bursts", 32'(href_rises), 32'd3);
        chk("href_count", 32'(href_cnt), 32'd12);
        chk("frame_done_count", 32'(fd_cnt), 32'd1);
        chk("rd_en_count", 32'(rden_cnt), 32'd12);
        chk("gray_count", 32'(gq.size()), 32'd12);
        for (int i = 0; i < 12; i++) begin
            if (i < gq.size()) chk("gray_seq", 32'(gq[i]), 32'(i));
            if (i < aq.size()) chk("addr_seq", 32'(aq[i]), 32'(i));
        end

        // Continuous mode: back-to-back frames, address restarts at 0.
        clear_stats();
        continuous = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        n = 0;
        while (fd_cnt == 0 && n < 60) begin step(); n++; end
        chk("cont_frame_done_seen", 32'(fd_cnt), 32'd1);
        step();
        chk("cont_busy_after_front", 32'(busy), 32'd1);
        n = 0;
        while (!rd_en && n < 60) begin step(); n++; end
        chk("cont_rd_en_seen", 32'(rd_en), 32'd1);
        chk("cont_addr_restart", 32'(rd_addr), 32'd0);
        continuous = 1'b0;
        repeat (40) step();
        chk("cont_frame_done_count", 32'(fd_cnt), 32'd2);
        chk("cont_href_count", 32'(href_cnt), 32'd24);

        // Reset in the middle of the second line.
        clear_stats();
        start = 1'b1;
        step();
        start = 1'b0;
        n = 0;
        while (!(rd_en && rd_addr == 20'd5) && n < 60) begin step(); n++; end
        chk("mid_line_reached", 32'(rd_addr), 32'd5);
        rst = 1'b1;
        step();
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_rd_en", 32'(rd_en), 32'd0);
        chk("midrst_addr", 32'(rd_addr), 32'd0);
        chk("midrst_fd", 32'(frame_done), 32'd0);
        chk("midrst_vsync", 32'(per_img_vsync), 32'd0);
        chk("midrst_href", 32'(per_img_href), 32'd0);
        chk("midrst_gray", 32'(per_img_gray), 32'd0);
        rst = 1'b0;
        clear_stats();
        repeat (30) step();
        chk("post_rst_href_count", 32'(href_cnt), 32'd0);
        chk("post_rst_busy", 32'(busy), 32'd0);

`ifdef IMG_STREAM_TEST_PATTERN_EN
        // Test pattern: gray = column + line, no memory reads.
        clear_stats();
        pattern_sel = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (40) step();
        chk("pat_rd_en_count", 32'(rden_cnt), 32'd0);
        chk("pat_href_count", 32'(href_cnt), 32'd12);
        for (int i = 0; i < 4; i++) begin
            if (4 + i < gq.size()) chk("pat_line1", 32'(gq[4 + i]), 32'(i + 1));
        end
        pattern_sel = 1'b0;
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/img_stream_gen.md
IMG_STREAM_GEN -- requirements
Module: img_stream_gen

Interface
REQ-001 Parameter IMG_HDISP, default 11'd640, active pixels per line.
REQ-002 Parameter IMG_VDISP, default 11'd480, active lines per frame.
REQ-003 Parameter H_BLANK, default 8'd160, idle cycles after each line, href low.
REQ-004 Parameter V_BACK, default 8'd20, cycles with vsync high before first line.
REQ-005 Parameter V_FRONT, default 8'd20, cycles with vsync low after last line's blank.
REQ-006 Port clk  input  1  sole clock, rising edge.
REQ-007 Port rst  input  1  synchronous, active-high reset.
REQ-008 Port start  input  1  one-cycle pulse that requests a frame.
REQ-009 Port continuous  input  1  when high, frames repeat without a new start.
REQ-010 Port busy  output  1  high in every state except IDLE.
REQ-011 Port frame_done  output  1  one-cycle pulse on the last V_FRONT cycle.
REQ-012 Port rd_en  output  1  pixel memory read strobe.
REQ-013 Port rd_addr  output  20  pixel address, raster order from 0.
REQ-014 Port rd_data  input  8  memory data, valid exactly 1 cycle after rd_en.
REQ-015 Port per_img_vsync / per_img_href  output  1 each  stream sync to the filter input.
REQ-016 Port per_img_gray  output  8  stream pixel.

Function
REQ-017 FSM states: IDLE, VBACK, LINE, HBLANK, VFRONT.
REQ-018 IDLE->VBACK on start; start is ignored in all other states.
REQ-019 VBACK lasts V_BACK cycles, then LINE.
REQ-020 LINE lasts IMG_HDISP cycles with rd_en=1 and rd_addr incrementing by 1 per cycle, then HBLANK.
REQ-021 HBLANK lasts H_BLANK cycles; it goes to LINE if lines remain, otherwise to VFRONT.
REQ-022 VFRONT lasts V_FRONT cycles, then goes to VBACK if continuous=1, otherwise to IDLE; frame_done pulses on its last cycle.
REQ-023 rd_addr resets to 0 on entry to VBACK; line and column counters are 11 bits and clear on wrap.
REQ-024 Internal vsync_i is 1 in VBACK/LINE/HBLANK; internal href_i is 1 in LINE.
REQ-025 Latency: per_img_vsync and per_img_href equal vsync_i and href_i delayed 2 cycles; per_img_gray is rd_data registered once, so the pixel read at t appears at t+2.
REQ-026 per_img_gray is 0 whenever per_img_href=0.
REQ-027 Each frame has exactly IMG_HDISP*IMG_VDISP href-high cycles.
REQ-028 If H_BLANK=0, LINE goes directly to LINE, so href stays continuous across lines.

Reset
REQ-029 On rst the FSM goes to IDLE and all counters clear.
REQ-030 On rst, rd_en, rd_addr, busy, frame_done, per_img_vsync, per_img_href and per_img_gray go to 0 on the next edge, including mid-frame.
REQ-031 After rst releases, the block waits for a new start.

Configuration
REQ-032 With macro IMG_STREAM_TEST_PATTERN_EN defined, an input port pattern_sel (1 bit) is added.
REQ-033 With the macro defined and pattern_sel=1, per_img_gray = (column + line) mod 256, rd_en stays 0, and timing is unchanged.
REQ-034 Without the macro, pattern_sel is absent and pixels always come from rd_data.

Structure
REQ-035 Package img_stream_pkg holds the FSM state encoding, the 20-bit address width constant and the 8-bit pixel width constant.
REQ-036 One sub-module, img_sync_delay, holds the 2-stage vsync/href delay line.

Verification (IMG_HDISP=4, IMG_VDISP=3, H_BLANK=2, V_BACK=3, V_FRONT=2)
REQ-037 Scenario: start at cycle 0 -> vsync rises at cycle 3; 3 href bursts of 4 cycles with 2-cycle gaps; frame_done once; 12 rd_en pulses with addresses 0..11.
REQ-038 Scenario: memory returns data=addr -> per_img_gray sequence 0..11, each aligned with href high.
REQ-039 Scenario: continuous=1 -> second VBACK starts the cycle after VFRONT ends; rd_addr restarts at 0.
REQ-040 Scenario: rst asserted during line 2 -> all outputs 0 next cycle; no href until the next start.
REQ-041 Scenario: start pulsed while busy -> ignored; exactly one frame is produced.
REQ-042 Scenario: macro defined, pattern_sel=1 -> line 1 pixels are 1,2,3,4 and rd_en never asserts.
